// File: rtl/supermic_pkg.sv
// Shared definitions for the supermic audio front end.
// Contents: default I2S slot geometry and the I2S receiver FSM state encoding.
package supermic_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned PCM_W_DEF  = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/i2s_sign_check.sv
// Sign-extension consistency checker for a received I2S word.
// Ports:
//   ext_bits   - the sign bit of the PCM sample plus every extension bit above it
//   sign_bad_c - combinational flag, high when those bits are not all equal
module i2s_sign_check #(
    parameter int unsigned EXT_W = 11
) (
    input  logic [EXT_W-1:0] ext_bits,
    output logic             sign_bad_c
);

    // Consistent only when every bit is 0 or every bit is 1.
    assign sign_bad_c = !((&ext_bits) || !(|ext_bits));

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: one-bit-delayed MSB-first slot capture with a single-entry
// valid/ready output register.
// Parameters:
//   WORD_W - serial bits per channel slot
//   PCM_W  - significant PCM bits at the LSB end of the slot
// Ports:
//   clk       - system clock, also the serial bit clock (rising edge)
//   rst       - asynchronous active-high reset
//   lr_clk    - word select, 0 = left slot, 1 = right slot
//   sd_in     - serial data, MSB first
//   out_data  - received word
//   out_right - channel of out_data (1 = right)
//   out_valid - out_data holds an unconsumed word
//   out_ready - downstream accept
//   frame_err - one-cycle pulse when a slot ends before WORD_W bits
//   overrun   - one-cycle pulse when a completed word is dropped
//   sign_err  - one-cycle pulse on inconsistent sign extension
// Build option: define SUPERMIC_I2S_RX_SIGN_CHECK_EN to include the sign
// checker; otherwise sign_err is tied to 0.
module i2s_rx
    import supermic_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned PCM_W  = PCM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lr_clk,
    input  logic              sd_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              sign_err
);

    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    // Reject geometries the slot datapath cannot represent.
    if (WORD_W < 2 || PCM_W == 0 || PCM_W > WORD_W) begin : g_bad_geometry
        $error("i2s_rx: need WORD_W >= 2 and 1 <= PCM_W <= WORD_W");
    end

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic              lr_q;
    logic              edge_c;
    logic [WORD_W-2:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              slot_right;
    logic              capture_c;
    logic              first_bit_c;
    logic              word_done_c;
    logic              short_slot_c;
    logic              load_c;
    logic [WORD_W-1:0] word_c;

    assign edge_c = lr_clk != lr_q;
    // Word as it stands once the current bit is shifted in.
    assign word_c = {shift_reg, sd_in};
    // A completed word is dropped only when the held word is not being taken.
    assign load_c = word_done_c && !(out_valid && !out_ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and slot control; an edge always wins over bit capture.
    always_comb begin
        state_nxt    = state;
        capture_c    = 1'b0;
        first_bit_c  = 1'b0;
        word_done_c  = 1'b0;
        short_slot_c = 1'b0;
        case (state)
            IDLE: begin
                if (edge_c) begin
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (edge_c) begin
                    short_slot_c = 1'b1;
                    state_nxt    = DELAY;
                end else begin
                    capture_c   = 1'b1;
                    first_bit_c = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (edge_c) begin
                    short_slot_c = 1'b1;
                    state_nxt    = DELAY;
                end else begin
                    capture_c = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        word_done_c = 1'b1;
                        state_nxt   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (edge_c) begin
                    state_nxt = DELAY;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Edge detector, channel latch, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_q       <= 1'b0;
            slot_right <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
        end else begin
            lr_q <= lr_clk;
            if (edge_c) begin
                slot_right <= lr_clk;
            end
            if (capture_c) begin
                shift_reg <= word_c[WORD_W-2:0];
                bit_cnt   <= first_bit_c ? CNT_W'(1) : bit_cnt + CNT_W'(1);
            end
        end
    end

    // Output register with single-entry handshake and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_right <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= short_slot_c;
            overrun   <= word_done_c && !load_c;
            if (load_c) begin
                out_data  <= word_c;
                out_right <= slot_right;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SUPERMIC_I2S_RX_SIGN_CHECK_EN
    logic sign_bad_c;

    i2s_sign_check #(
        .EXT_W (WORD_W - PCM_W + 1)
    ) u_sign_check (
        .ext_bits   (word_c[WORD_W-1:PCM_W-1]),
        .sign_bad_c (sign_bad_c)
    );

    // Flag rides along with the load; the word is delivered regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_err <= 1'b0;
        end else begin
            sign_err <= load_c && sign_bad_c;
        end
    end
`else
    assign sign_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed slot scenarios plus randomized
// slots and backpressure, compared against a slot-level reference model.
module tb_i2s_rx;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PCM_W  = 22;
`ifdef SUPERMIC_I2S_RX_SIGN_CHECK_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              lr_clk;
    logic              sd_in;
    logic [WORD_W-1:0] out_data;
    logic              out_right;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic              overrun;
    logic              sign_err;

    i2s_rx #(
        .WORD_W (WORD_W),
        .PCM_W  (PCM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lr_clk    (lr_clk),
        .sd_in     (sd_in),
        .out_data  (out_data),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .sign_err  (sign_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: position within the current slot and its bits.
    bit          m_prev_lr;
    bit          m_active;
    int          m_pos;
    bit          m_ch;
    logic [31:0] m_bits;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_right;
    bit          exp_ferr;
    bit          exp_ovr;
    bit          exp_serr;

    // Observations collected by send_slot.
    bit          rand_ready = 1'b0;
    int          dut_ferr_cnt = 0;
    int          dut_ovr_cnt  = 0;
    logic        pre_valid;
    logic        seen_valid;
    logic [31:0] seen_data;
    logic        seen_right;
    logic        seen_serr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit sign_bad(input logic [31:0] w);
        longint unsigned top;
        longint unsigned ones;
        top  = longint'(w) >> (PCM_W - 1);
        ones = (64'd1 << (WORD_W - PCM_W + 1)) - 64'd1;
        return !(top == 0 || top == ones);
    endfunction

    task automatic model_reset();
        m_prev_lr = 1'b0;
        m_active  = 1'b0;
        m_pos     = 0;
        m_ch      = 1'b0;
        m_bits    = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_right = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_serr  = 1'b0;
    endtask

    // One clock of the model, from the inputs seen at that rising edge.
    task automatic model_step(input bit l, input bit s, input bit rdy);
        bit done;
        bit edge_seen;
        done      = 1'b0;
        edge_seen = (l != m_prev_lr);
        m_prev_lr = l;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_serr  = 1'b0;
        if (edge_seen) begin
            // The old slot delivered m_pos bits before this edge.
            if (m_active && m_pos < int'(WORD_W)) exp_ferr = 1'b1;
            m_active = 1'b1;
            m_pos    = 0;
            m_ch     = l;
            m_bits   = '0;
        end else begin
            if (m_pos < 100000) m_pos++;
            if (m_active && m_pos >= 1 && m_pos <= int'(WORD_W)) begin
                m_bits = {m_bits[30:0], s};
                if (m_pos == int'(WORD_W)) done = 1'b1;
            end
        end
        if (done) begin
            if (exp_valid && !rdy) begin
                exp_ovr = 1'b1;
            end else begin
                exp_valid = 1'b1;
                exp_data  = m_bits;
                exp_right = m_ch;
                exp_serr  = SIGN_EN && sign_bad(m_bits);
            end
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic tick(input logic l, input logic s);
        lr_clk = l;
        sd_in  = s;
        if (rand_ready) out_ready = 1'($urandom);
        @(posedge clk);
        model_step(l, s, out_ready);
        #1;
        if (frame_err === 1'b1) dut_ferr_cnt++;
        if (overrun === 1'b1) dut_ovr_cnt++;
        check("valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("data", out_data, exp_data);
            check("right", 32'(out_right), 32'(exp_right));
        end
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("sign_err", 32'(sign_err), 32'(exp_serr));
    endtask

    // Drive one slot of len cycles on channel ch; bits follow the one-bit delay.
    task automatic send_slot(input logic ch, input int len, input logic [31:0] word, input int rdy_at);
        pre_valid  = 1'bx;
        seen_valid = 1'bx;
        seen_data  = 'x;
        seen_right = 1'bx;
        seen_serr  = 1'bx;
        for (int k = 0; k < len; k++) begin
            logic s;
            if (k >= 1 && k <= int'(WORD_W)) s = word[WORD_W - k];
            else s = 1'($urandom);
            if (rdy_at >= 0 && k == rdy_at) out_ready = 1'b1;
            tick(ch, s);
            if (k == int'(WORD_W) - 1) pre_valid = out_valid;
            if (k == int'(WORD_W)) begin
                seen_valid = out_valid;
                seen_data  = out_data;
                seen_right = out_right;
                seen_serr  = sign_err;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, out_data, 32'h0);
        check({tag, "_right"}, 32'(out_right), 32'h0);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_ferr"}, 32'(frame_err), 32'h0);
        check({tag, "_ovr"}, 32'(overrun), 32'h0);
        check({tag, "_serr"}, 32'(sign_err), 32'h0);
    endtask

    // Asynchronous reset in the middle of a cycle, released on a falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int f0;
        int o0;
        rst       = 1'b1;
        lr_clk    = 1'b0;
        sd_in     = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Basic left slot, preceded by a right slot so the 1->0 edge exists.
        send_slot(1'b1, 34, $urandom, -1);
        send_slot(1'b0, 34, 32'hFFE00001, -1);
        check("s1_early_valid", 32'(pre_valid), 32'h0);
        check("s1_valid", 32'(seen_valid), 32'h1);
        check("s1_data", seen_data, 32'hFFE00001);
        check("s1_right", 32'(seen_right), 32'h0);

        // Alternating slots with out_ready held high.
        send_slot(1'b1, 34, $urandom, -1);
        f0 = dut_ferr_cnt;
        o0 = dut_ovr_cnt;
        send_slot(1'b0, 33, 32'h00000005, -1);
        check("alt_l_data", seen_data, 32'h00000005);
        check("alt_l_right", 32'(seen_right), 32'h0);
        send_slot(1'b1, 33, 32'hFFFFFFFB, -1);
        check("alt_r_data", seen_data, 32'hFFFFFFFB);
        check("alt_r_right", 32'(seen_right), 32'h1);
        check("alt_errs", 32'(dut_ferr_cnt - f0 + dut_ovr_cnt - o0), 32'h0);

        // Short slot: the edge arrives after only 20 bits.
        f0 = dut_ferr_cnt;
        send_slot(1'b0, 21, $urandom, -1);
        send_slot(1'b1, 34, 32'h12345678, -1);
        check("short_ferr", 32'(dut_ferr_cnt - f0), 32'h1);
        check("short_next_data", seen_data, 32'h12345678);
        check("short_next_right", 32'(seen_right), 32'h1);

        // Backpressure across two slots, then ready rises with a third completion.
        out_ready = 1'b0;
        o0 = dut_ovr_cnt;
        send_slot(1'b0, 34, 32'hA5A5A5A5, -1);
        check("bp_first", seen_data, 32'hA5A5A5A5);
        send_slot(1'b1, 34, 32'h0F0F0F0F, -1);
        check("bp_ovr", 32'(dut_ovr_cnt - o0), 32'h1);
        check("bp_held", seen_data, 32'hA5A5A5A5);
        check("bp_held_right", 32'(seen_right), 32'h0);
        o0 = dut_ovr_cnt;
        send_slot(1'b0, 34, 32'h3C3C3C3C, int'(WORD_W));
        check("bp_third_valid", 32'(seen_valid), 32'h1);
        check("bp_third_data", seen_data, 32'h3C3C3C3C);
        check("bp_third_ovr", 32'(dut_ovr_cnt - o0), 32'h0);

        // Reset asserted once bit 15 of a right slot has been sampled.
        for (int k = 0; k <= 15; k++) tick(1'b1, 1'($urandom));
        async_reset("rst_mid");
        f0 = dut_ferr_cnt;
        send_slot(1'b1, 34, 32'hCAFE0123, -1);
        check("rst_post_data", seen_data, 32'hCAFE0123);
        check("rst_post_right", 32'(seen_right), 32'h1);
        check("rst_post_ferr", 32'(dut_ferr_cnt - f0), 32'h0);

        // Inconsistent sign extension above the 22-bit sample.
        send_slot(1'b0, 34, 32'h00200000, -1);
        check("sign_data", seen_data, 32'h00200000);
        check("sign_err", 32'(seen_serr), 32'(SIGN_EN));

        // lr_clk toggling too fast: every slot is short.
        f0 = dut_ferr_cnt;
        for (int i = 0; i < 5; i++) send_slot(1'(i % 2 == 0), 5, $urandom, -1);
        send_slot(1'b0, 34, 32'h00000042, -1);
        check("fast_ferr", 32'(dut_ferr_cnt - f0), 32'h5);
        check("fast_next_data", seen_data, 32'h00000042);

        // Randomized slot lengths, data and backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_slot(~lr_clk, int'($urandom_range(2, WORD_W + 6)), $urandom, -1);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        send_slot(~lr_clk, 34, $urandom, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning serial bits per channel slot.
REQ-002 SHALL have parameter PCM_W, default 22, meaning significant PCM bits at the LSB end of the slot; all bits above are sign extension.
REQ-003 SHALL have port clk, input, 1, the single clock; it is also the serial bit clock, and all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port lr_clk, input, 1, word select: 0 selects the left slot, 1 selects the right slot.
REQ-006 SHALL have port sd_in, input, 1, serial data, MSB first.
REQ-007 SHALL have port out_data, output, WORD_W, the received word.
REQ-008 SHALL have port out_right, output, 1, the channel of out_data (1 = right).
REQ-009 SHALL have port out_valid, output, 1, which is high while out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-011 SHALL have port frame_err, output, 1, a one-cycle pulse on a short slot.
REQ-012 SHALL have port overrun, output, 1, a one-cycle pulse when a completed word is dropped.
REQ-013 SHALL have port sign_err, output, 1, a one-cycle pulse on inconsistent sign extension (present only with the macro in REQ-030).

Function
REQ-014 SHALL register lr_clk into lr_q each cycle; a slot edge is the condition lr_clk != lr_q.
REQ-015 SHALL sample the MSB on sd_in in the cycle after the edge-detect cycle (I2S one-bit delay), then shift in the following WORD_W-1 bits on consecutive cycles.
REQ-016 SHALL use FSM states IDLE, DELAY, SHIFT and HOLD.
REQ-017 SHALL implement these transitions:
  - IDLE: waits for the first edge.
  - IDLE/HOLD -> DELAY on an edge.
  - DELAY -> SHIFT on the next cycle, which captures the MSB.
  - SHIFT -> HOLD after the WORD_W-th bit.
REQ-018 SHALL latch the slot channel as the lr_clk value sampled in the edge-detect cycle.
REQ-019 SHALL, on an edge during DELAY or SHIFT before WORD_W bits are captured, discard the partial word, pulse frame_err, and go to DELAY for the new slot.
REQ-020 SHALL, in HOLD, ignore bits beyond WORD_W until the next edge.
REQ-021 SHALL complete a word in the cycle its WORD_W-th bit is sampled; the word SHALL appear on out_data with out_valid=1 in the next cycle (latency 1 after the last bit).
REQ-022 SHALL keep out_data, out_right and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, if a word completes while out_valid=1 and out_ready=0, drop the new word, keep the old one, and pulse overrun.
REQ-024 SHALL, if a word completes in the same cycle out_valid=1 and out_ready=1, accept the old word and load the new one, with out_valid remaining 1 and no overrun.
REQ-025 SHALL clear out_valid on out_ready when no word completes in that cycle.
REQ-026 SHALL allow lr_clk toggling faster than WORD_W+1 cycles, with the result that every slot produces frame_err and no output.

Reset
REQ-027 SHALL, on rst, immediately drive: state = IDLE, shift register = 0, bit counter = 0, lr_q = 0, out_data = 0, out_right = 0, out_valid = 0, frame_err = 0, overrun = 0, sign_err = 0.
REQ-028 SHALL discard any partially received or unconsumed word on reset mid-slot.
REQ-029 SHALL, after reset release, treat the first observed edge as the start of reception; it SHALL NOT produce a frame_err.

Configuration
REQ-030 SHALL compile a sign-extension checker only when macro SUPERMIC_I2S_RX_SIGN_CHECK_EN is defined.
REQ-031 SHALL, with the macro defined, pulse sign_err together with the out_valid load when bits [WORD_W-1:PCM_W-1] of the completed word are not all equal; the word SHALL still be delivered.
REQ-032 SHALL, without the macro, tie sign_err to 0 and omit the checker logic.

Structure
REQ-033 SHALL place the FSM state enum and the WORD_W/PCM_W defaults in the shared package supermic_pkg.
REQ-034 SHALL implement the sign checker as the sub-module i2s_sign_check, instantiated only under the macro.

Verification
REQ-035 SHALL include a basic left-slot scenario: reset, then lr_clk 1->0 followed by 32 bits of 0xFFE00001 -> out_data=0xFFE00001, out_right=0, out_valid one cycle after the 32nd bit.
REQ-036 SHALL include an alternating-slot scenario: left 0x00000005, right 0xFFFFFFFB, with out_ready=1 throughout -> two words in order with out_right 0 then 1, and no errors.
REQ-037 SHALL include a short-slot scenario: an edge after 20 bits -> frame_err pulse, no out_valid, and the next full slot received correctly.
REQ-038 SHALL include a backpressure scenario: out_ready=0 across two slots -> first word held, overrun pulse at the second completion; then out_ready=1 together with a third completion -> third word loaded with out_valid held at 1.
REQ-039 SHALL include a reset-mid-shift scenario: rst asserted at bit 15 -> all outputs 0 immediately, and the first post-reset edge starts clean reception.
REQ-040 SHALL include a sign-check scenario, with the macro defined: word 0x00200000 -> delivered with a sign_err pulse; with the macro undefined, sign_err stays 0.
